// File: rtl/gh_pkg.sv
// Shared definitions for the note pipeline (scheduler and judge).
// Lane count, judge FSM states, score/combo widths and the multiplier rule.
package gh_pkg;

    localparam int LANES      = 5;
    localparam int MULT_MAX   = 4;
    localparam int COMBO_STEP = 10;
    localparam int SCORE_W    = 16;
    localparam int COMBO_W    = 8;

    typedef enum logic {
        IDLE  = 1'b0,
        ARMED = 1'b1
    } judge_state_t;

    // One multiplier step per COMBO_STEP consecutive hits, capped at MULT_MAX.
    function automatic logic [2:0] mult_of(input logic [COMBO_W-1:0] combo);
        if (int'(combo) < COMBO_STEP) return 3'd1;
        else if (int'(combo) < 2 * COMBO_STEP) return 3'd2;
        else if (int'(combo) < 3 * COMBO_STEP) return 3'd3;
        else return 3'(MULT_MAX);
    endfunction

endpackage

// File: rtl/judge_scorer.sv
// Combo, multiplier and saturating score bookkeeping driven by judge hit/miss.
module judge_scorer
    import gh_pkg::*;
#(
    parameter int BASE_POINTS = 10
) (
    input  logic               clk,
    input  logic               resetn,
    input  logic               hit,
    input  logic               miss,
    output logic [SCORE_W-1:0] score,
    output logic [COMBO_W-1:0] combo,
    output logic [2:0]         multiplier
);

    logic [31:0]        sum;
    logic [COMBO_W-1:0] combo_nxt;

    // The points use the multiplier in force before this hit.
    always_comb begin
        sum       = 32'(score) + 32'(BASE_POINTS) * 32'(multiplier);
        combo_nxt = combo;
        if (hit) begin
            if (combo != '1) combo_nxt = combo + COMBO_W'(1);
        end else if (miss) begin
            combo_nxt = '0;
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            score      <= '0;
            combo      <= '0;
            multiplier <= 3'd1;
        end else begin
            if (hit) score <= (|sum[31:SCORE_W]) ? '1 : sum[SCORE_W-1:0];
            combo      <= combo_nxt;
            multiplier <= mult_of(combo_nxt);
        end
    end

endmodule

// File: rtl/note_judge.sv
// Judges expected notes against fret/strum input inside a timing window.
// Define NOTE_JUDGE_OVERSTRUM_EN to count strum edges in IDLE as misses.
module note_judge
    import gh_pkg::*;
#(
    parameter int WINDOW      = 6578947,
    parameter int CNT_W       = 24,
    parameter int BASE_POINTS = 10
) (
    input  logic               clk,
    input  logic               resetn,
    input  logic               pause,
    input  logic [LANES-1:0]   exp_notes,
    input  logic [LANES-1:0]   frets,
    input  logic               strum,
    output logic               hit,
    output logic               miss,
    output logic [SCORE_W-1:0] score,
    output logic [COMBO_W-1:0] combo,
    output logic [2:0]         multiplier
);

    // The onset edge itself is the first accepted edge, so the counter value
    // sampled on the last accepted edge is WINDOW-2.
    localparam logic [CNT_W-1:0] LAST = CNT_W'(WINDOW - 2);

    judge_state_t     state, state_nxt;
    logic             strum_q;
    logic [LANES-1:0] prev_notes, target;
    logic [CNT_W-1:0] cnt;
    logic             strum_edge, onset, expire, match_new, match_old;
    logic             hit_nxt, miss_nxt;

    assign strum_edge = strum & ~strum_q;
    assign onset      = (exp_notes != '0) && (exp_notes != prev_notes);
    assign expire     = (cnt == LAST);
    assign match_new  = (frets == exp_notes);
    assign match_old  = (frets == target);

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) state <= IDLE;
        else         state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        if (!pause) begin
            case (state)
                IDLE:  if (onset && !strum_edge) state_nxt = ARMED;
                ARMED: begin
                    if (strum_edge)  state_nxt = IDLE;
                    else if (onset)  state_nxt = ARMED;
                    else if (expire) state_nxt = IDLE;
                end
                default: state_nxt = IDLE;
            endcase
        end
    end

    // A strum coinciding with an onset is judged against the new note only.
    always_comb begin
        hit_nxt  = 1'b0;
        miss_nxt = 1'b0;
        if (!pause) begin
            case (state)
                IDLE: begin
                    if (strum_edge && onset) begin
                        hit_nxt  = match_new;
                        miss_nxt = !match_new;
                    end
`ifdef NOTE_JUDGE_OVERSTRUM_EN
                    else if (strum_edge) begin
                        miss_nxt = 1'b1;
                    end
`endif
                end
                ARMED: begin
                    if (strum_edge) begin
                        hit_nxt  = onset ? match_new : match_old;
                        miss_nxt = onset ? !match_new : !match_old;
                    end else if (onset || expire) begin
                        miss_nxt = 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            strum_q    <= 1'b0;
            prev_notes <= '0;
            target     <= '0;
            cnt        <= '0;
            hit        <= 1'b0;
            miss       <= 1'b0;
        end else begin
            strum_q    <= strum;
            prev_notes <= exp_notes;
            hit        <= hit_nxt;
            miss       <= miss_nxt;
            if (!pause && onset && !strum_edge) begin
                target <= exp_notes;
                cnt    <= '0;
            end else if (!pause && state == ARMED) begin
                cnt <= cnt + CNT_W'(1);
            end
        end
    end

    judge_scorer #(.BASE_POINTS(BASE_POINTS)) u_scorer (
        .clk        (clk),
        .resetn     (resetn),
        .hit        (hit_nxt),
        .miss       (miss_nxt),
        .score      (score),
        .combo      (combo),
        .multiplier (multiplier)
    );

endmodule

// File: tb/tb_note_judge.sv
// Directed bench for note_judge with WINDOW=8: cycle table plus pause,
// long-combo/saturation and reset-mid-window sequences.
module tb_note_judge;

`ifdef NOTE_JUDGE_OVERSTRUM_EN
    localparam int OVS = 1;
`else
    localparam int OVS = 0;
`endif

    logic        clk = 1'b0;
    logic        resetn = 1'b0;
    logic        pause = 1'b0;
    logic        strum = 1'b0;
    logic [4:0]  exp_notes = 5'b0;
    logic [4:0]  frets = 5'b0;
    logic        hit, miss;
    logic [15:0] score;
    logic [7:0]  combo;
    logic [2:0]  multiplier;

    int n_checks = 0;
    int n_errors = 0;

    note_judge #(.WINDOW(8), .CNT_W(4), .BASE_POINTS(10)) dut (
        .clk        (clk),
        .resetn     (resetn),
        .pause      (pause),
        .exp_notes  (exp_notes),
        .frets      (frets),
        .strum      (strum),
        .hit        (hit),
        .miss       (miss),
        .score      (score),
        .combo      (combo),
        .multiplier (multiplier)
    );

    always #5 clk = ~clk;

    typedef struct {
        int p; int e; int f; int s;
        int h; int m; int sc; int co; int mu;
    } vec_t;

    vec_t vq[$];

    task automatic add(input int p, input int e, input int f, input int s,
                       input int h, input int m, input int sc, input int co, input int mu);
        vec_t v;
        v.p = p; v.e = e; v.f = f; v.s = s;
        v.h = h; v.m = m; v.sc = sc; v.co = co; v.mu = mu;
        vq.push_back(v);
    endtask

    task automatic chk(input string nm, input int act, input int expv);
        n_checks++;
        if (act !== expv) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", nm, act, expv);
        end
    endtask

    task automatic step(input int p, input int e, input int f, input int s);
        pause     = p[0];
        exp_notes = e[4:0];
        frets     = f[4:0];
        strum     = s[0];
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        resetn    = 1'b0;
        pause     = 1'b0;
        strum     = 1'b0;
        exp_notes = 5'b0;
        frets     = 5'b0;
        repeat (2) @(posedge clk);
        #1;
        resetn = 1'b1;
    endtask

    int m_score, m_combo, m_mult, co_ovs, e;

    initial begin
        co_ovs = (OVS != 0) ? 0 : 1;

        // test 1: idle after reset
        repeat (3) add(0, 0, 0, 0, 0, 0, 0, 0, 1);
        // test 2: strum 3 cycles after onset
        repeat (3) add(0, 5'b00101, 5'b00101, 0, 0, 0, 0, 0, 1);
        add(0, 5'b00101, 5'b00101, 1, 1, 0, 10, 1, 1);
        add(0, 5'b00101, 5'b00101, 1, 0, 0, 10, 1, 1);
        add(0, 0, 0, 0, 0, 0, 10, 1, 1);
        // test 3: expiry at onset+7
        repeat (7) add(0, 5'b01010, 0, 0, 0, 0, 10, 1, 1);
        add(0, 5'b01010, 0, 0, 0, 1, 10, 0, 1);
        add(0, 5'b01010, 0, 0, 0, 0, 10, 0, 1);
        add(0, 0, 0, 0, 0, 0, 10, 0, 1);
        // test 5: replaced note, then strum on the expiry edge wins
        add(0, 5'b11000, 0, 0, 0, 0, 10, 0, 1);
        add(0, 5'b10100, 0, 0, 0, 1, 10, 0, 1);
        repeat (6) add(0, 5'b10100, 0, 0, 0, 0, 10, 0, 1);
        add(0, 5'b10100, 5'b10100, 1, 1, 0, 20, 1, 1);
        add(0, 0, 0, 0, 0, 0, 20, 1, 1);
        // extra fret held is a wrong strum
        add(0, 5'b00011, 0, 0, 0, 0, 20, 1, 1);
        add(0, 5'b00011, 5'b00111, 1, 0, 1, 20, 0, 1);
        add(0, 0, 0, 0, 0, 0, 20, 0, 1);
        // onset and strum in the same cycle
        add(0, 5'b00110, 5'b00110, 1, 1, 0, 30, 1, 1);
        add(0, 5'b00110, 5'b00110, 1, 0, 0, 30, 1, 1);
        add(0, 0, 0, 0, 0, 0, 30, 1, 1);
        // strum in IDLE: overstrum only when enabled
        add(0, 0, 0, 1, 0, OVS, 30, co_ovs, 1);
        add(0, 0, 0, 0, 0, 0, 30, co_ovs, 1);
        // strum edge while paused in IDLE, held across un-pause
        add(1, 0, 0, 0, 0, 0, 30, co_ovs, 1);
        add(1, 0, 0, 1, 0, 0, 30, co_ovs, 1);
        add(0, 0, 0, 1, 0, 0, 30, co_ovs, 1);
        add(0, 0, 0, 0, 0, 0, 30, co_ovs, 1);

        do_reset();
        chk("reset_hit", int'(hit), 0);
        chk("reset_miss", int'(miss), 0);
        chk("reset_score", int'(score), 0);
        chk("reset_combo", int'(combo), 0);
        chk("reset_mult", int'(multiplier), 1);

        foreach (vq[i]) begin
            step(vq[i].p, vq[i].e, vq[i].f, vq[i].s);
            chk($sformatf("row%0d_hit", i), int'(hit), vq[i].h);
            chk($sformatf("row%0d_miss", i), int'(miss), vq[i].m);
            chk($sformatf("row%0d_score", i), int'(score), vq[i].sc);
            chk($sformatf("row%0d_combo", i), int'(combo), vq[i].co);
            chk($sformatf("row%0d_mult", i), int'(multiplier), vq[i].mu);
        end

        // pause mid-window: 2 window cycles used, 20 paused, 5 remaining
        do_reset();
        step(0, 5'b01010, 5'b01010, 0);
        chk("pause_onset_miss", int'(miss), 0);
        repeat (2) begin
            step(0, 5'b01010, 5'b01010, 0);
            chk("pause_pre_miss", int'(miss), 0);
        end
        for (int i = 0; i < 20; i++) begin
            step(1, 5'b01010, 5'b01010, i % 2);
            chk($sformatf("paused%0d_hit", i), int'(hit), 0);
            chk($sformatf("paused%0d_miss", i), int'(miss), 0);
        end
        for (int j = 1; j <= 5; j++) begin
            step(0, 5'b01010, 5'b01010, 1);
            chk($sformatf("unpause%0d_hit", j), int'(hit), 0);
            chk($sformatf("unpause%0d_miss", j), int'(miss), (j == 5) ? 1 : 0);
        end
        step(0, 0, 0, 0);
        chk("unpause_after_miss", int'(miss), 0);

        // long run of correct hits: multiplier steps, combo and score saturation
        do_reset();
        m_score = 0; m_combo = 0; m_mult = 1;
        for (int i = 1; i <= 1700; i++) begin
            e = (i % 2 != 0) ? 5'b00001 : 5'b00010;
            step(0, e, e, 1);
            m_score = m_score + 10 * m_mult;
            if (m_score > 65535) m_score = 65535;
            if (m_combo < 255) m_combo++;
            m_mult = (m_combo < 10) ? 1 : (m_combo < 20) ? 2 : (m_combo < 30) ? 3 : 4;
            chk($sformatf("run%0d_hit", i), int'(hit), 1);
            chk($sformatf("run%0d_miss", i), int'(miss), 0);
            chk($sformatf("run%0d_score", i), int'(score), m_score);
            chk($sformatf("run%0d_combo", i), int'(combo), m_combo);
            chk($sformatf("run%0d_mult", i), int'(multiplier), m_mult);
            if (i == 9)  chk("mult_after_9", int'(multiplier), 1);
            if (i == 10) chk("mult_after_10", int'(multiplier), 2);
            if (i == 11) chk("score_after_11", int'(score), 120);
            if (i == 30) chk("mult_after_30", int'(multiplier), 4);
            if (i == 300) chk("combo_sat", int'(combo), 255);
            step(0, e, e, 0);
            chk($sformatf("run%0d_gap_hit", i), int'(hit), 0);
        end
        chk("score_sat", int'(score), 65535);

        // reset mid-window drops the pending note without a miss
        step(0, 5'b00100, 0, 0);
        repeat (3) step(0, 5'b00100, 0, 0);
        resetn    = 1'b0;
        exp_notes = 5'b0;
        #2;
        chk("midrst_combo", int'(combo), 0);
        chk("midrst_score", int'(score), 0);
        chk("midrst_mult", int'(multiplier), 1);
        @(posedge clk);
        #1;
        resetn = 1'b1;
        for (int i = 0; i < 10; i++) begin
            step(0, 0, 0, 0);
            chk($sformatf("midrst%0d_miss", i), int'(miss), 0);
            chk($sformatf("midrst%0d_hit", i), int'(hit), 0);
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
